// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/accumulator front end.
// The branch table maps an r0 nibble to a 12-bit branch target.
package fetch_pkg;

    localparam int PC_W  = 12;
    localparam int DAT_W = 8;
    localparam int LUT_N = 16;
    localparam int IDX_W = $clog2(LUT_N);

    typedef logic [PC_W-1:0]  pc_t;
    typedef logic [DAT_W-1:0] slot_t;
    typedef logic [IDX_W-1:0] lut_idx_t;

    // Entry k points at 16*k.
    localparam pc_t BR_LUT [LUT_N] = '{
        12'h000, 12'h010, 12'h020, 12'h030,
        12'h040, 12'h050, 12'h060, 12'h070,
        12'h080, 12'h090, 12'h0A0, 12'h0B0,
        12'h0C0, 12'h0D0, 12'h0E0, 12'h0F0
    };

endpackage

// File: rtl/fetch_accum_unit_branch_lut.sv
// Branch target table: r0 low nibble in, 12-bit target out.
// Purely combinational, so a branch sees the pre-edge r0.
module branch_lut
    import fetch_pkg::*;
(
    input  lut_idx_t i_idx,
    output pc_t      o_target
);

    assign o_target = BR_LUT[i_idx];

endmodule

// File: rtl/fetch_accum_unit.sv
// Front-end state: program counter, branch table lookup and the
// three-slot operand accumulator that feeds the reg file and ALU.
module fetch_accum_unit
    import fetch_pkg::*;
#(
    parameter int DEBUG = 0
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  branch_flag,
    input  logic  put_en,
    input  logic  op_en,
    input  slot_t value,
    input  pc_t   control_ctr,
    output pc_t   prog_ctr,
    output pc_t   target,
    output slot_t r0,
    output slot_t r1,
    output slot_t r2,
    output pc_t   accumulator_ctr
);

    lut_idx_t w_idx;

    assign w_idx = r0[IDX_W-1:0];

    branch_lut u_lut (
        .i_idx    (w_idx),
        .o_target (target)
    );

    // Trace hooks live here; they never affect the datapath.
    if (DEBUG != 0) begin : g_debug
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prog_ctr <= '0;
        end else if (branch_flag) begin
            prog_ctr <= target;
        end else begin
            prog_ctr <= prog_ctr + pc_t'(1);
        end
    end

    // Clear-then-push when both enables are set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0              <= '0;
            r1              <= '0;
            r2              <= '0;
            accumulator_ctr <= '0;
        end else begin
            unique case ({put_en, op_en})
                2'b10: begin
                    r0 <= value;
                    r1 <= r0;
                    r2 <= r1;
                end
                2'b01: begin
                    r0 <= '0;
                    r1 <= '0;
                    r2 <= '0;
                end
                2'b11: begin
                    r0 <= value;
                    r1 <= '0;
                    r2 <= '0;
                end
                default: begin
                    r0 <= r0;
                    r1 <= r1;
                    r2 <= r2;
                end
            endcase
            if (put_en || op_en) begin
                accumulator_ctr <= control_ctr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_accum_unit.sv
// Scoreboard bench for fetch_accum_unit: a reference model pushes the
// expected post-edge state, each test pops and compares after the edge.
module tb_fetch_accum_unit;

    typedef struct packed {
        logic [11:0] pc;
        logic [11:0] tgt;
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [7:0]  s2;
        logic [11:0] actr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_flag;
    logic        put_en;
    logic        op_en;
    logic [7:0]  value;
    logic [11:0] control_ctr;
    logic [11:0] prog_ctr;
    logic [11:0] target;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [11:0] accumulator_ctr;

    exp_t sb[$];
    exp_t e;
    exp_t got;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] m_pc   = '0;
    logic [7:0]  m_r0   = '0;
    logic [7:0]  m_r1   = '0;
    logic [7:0]  m_r2   = '0;
    logic [11:0] m_actr = '0;

    always #5 clk = ~clk;

    fetch_accum_unit #(.DEBUG(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .branch_flag     (branch_flag),
        .put_en          (put_en),
        .op_en           (op_en),
        .value           (value),
        .control_ctr     (control_ctr),
        .prog_ctr        (prog_ctr),
        .target          (target),
        .r0              (r0),
        .r1              (r1),
        .r2              (r2),
        .accumulator_ctr (accumulator_ctr)
    );

    function automatic logic [11:0] m_tgt(input logic [7:0] s);
        logic [11:0] idx;
        idx = {8'h00, s[3:0]};
        return idx * 12'd16;
    endfunction

    // Drive one cycle, advance the model, push the expected result.
    task automatic drive(input logic rst, input logic br,
                         input logic put, input logic op,
                         input logic [7:0] val, input logic [11:0] ctr);
        exp_t x;
        reset = rst; branch_flag = br; put_en = put; op_en = op;
        value = val; control_ctr = ctr;
        if (rst) begin
            m_pc = '0; m_r0 = '0; m_r1 = '0; m_r2 = '0; m_actr = '0;
        end else begin
            m_pc = br ? m_tgt(m_r0) : m_pc + 12'd1;
            if (op) begin
                m_r0 = '0; m_r1 = '0; m_r2 = '0;
            end
            if (put) begin
                m_r2 = m_r1; m_r1 = m_r0; m_r0 = val;
            end
            if (put || op) m_actr = ctr;
        end
        x = '{pc: m_pc, tgt: m_tgt(m_r0), s0: m_r0, s1: m_r1,
              s2: m_r2, actr: m_actr};
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 12'h123);
            e = sb.pop_front();
            got = '{prog_ctr, target, r0, r1, r2, accumulator_ctr};
            checks++;
            if (got !== e || got !== '0) begin
                errors++;
                $display("FAIL reset: got %h want %h", got, e);
            end
        end
    endtask

    task automatic test_seq_fetch;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
            e = sb.pop_front();
            got = '{prog_ctr, target, r0, r1, r2, accumulator_ctr};
            checks++;
            if (got !== e || prog_ctr !== 12'(i)) begin
                errors++;
                $display("FAIL seq_fetch %0d: got %h want %h", i, got, e);
            end
        end
    endtask

    task automatic test_wrap;
        int bad = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
        void'(sb.pop_front());
        for (int i = 0; i < 4095; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
            e = sb.pop_front();
            if (prog_ctr !== e.pc) bad++;
        end
        checks++;
        if (bad != 0 || prog_ctr !== 12'hFFF) begin
            errors++;
            $display("FAIL pc_to_fff: got %h want fff (%0d bad)",
                     prog_ctr, bad);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
        e = sb.pop_front();
        checks++;
        if (prog_ctr !== e.pc || prog_ctr !== 12'h000) begin
            errors++;
            $display("FAIL pc_wrap: got %h want 000", prog_ctr);
        end
    endtask

    task automatic test_puts;
        logic [7:0] vals [4] = '{8'h03, 8'h07, 8'h0A, 8'h01};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, vals[i], 12'h010 + 12'(i));
            e = sb.pop_front();
            got = '{prog_ctr, target, r0, r1, r2, accumulator_ctr};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL put %0d: got %h want %h", i, got, e);
            end
        end
        checks++;
        if ({r0, r1, r2} !== 24'h010A07) begin
            errors++;
            $display("FAIL put_slots: got %h want 010a07", {r0, r1, r2});
        end
    endtask

    task automatic test_op;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 12'h02A);
        e = sb.pop_front();
        got = '{prog_ctr, target, r0, r1, r2, accumulator_ctr};
        checks++;
        if (got !== e || {r0, r1, r2} !== '0 || accumulator_ctr !== 12'h02A) begin
            errors++;
            $display("FAIL op_clear: got %h want %h", got, e);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 12'h077);
        e = sb.pop_front();
        checks++;
        if (accumulator_ctr !== e.actr || accumulator_ctr !== 12'h02A) begin
            errors++;
            $display("FAIL actr_hold: got %h want 02a", accumulator_ctr);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 12'h031);
        void'(sb.pop_front());
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 12'h032);
        e = sb.pop_front();
        got = '{prog_ctr, target, r0, r1, r2, accumulator_ctr};
        checks++;
        if (got !== e || {r0, r1, r2} !== 24'h090000) begin
            errors++;
            $display("FAIL put_op: got %h want %h", got, e);
        end
    endtask

    task automatic test_branch;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 12'h040);
        e = sb.pop_front();
        checks++;
        if (target !== e.tgt || target !== 12'h030) begin
            errors++;
            $display("FAIL target_03: got %h want 030", target);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h041);
        e = sb.pop_front();
        checks++;
        if (prog_ctr !== e.pc || prog_ctr !== 12'h030) begin
            errors++;
            $display("FAIL branch_pc: got %h want 030", prog_ctr);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h13, 12'h042);
        e = sb.pop_front();
        checks++;
        if (target !== e.tgt || target !== 12'h030) begin
            errors++;
            $display("FAIL target_13: got %h want 030", target);
        end
    endtask

    task automatic test_reset_branch;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h0C, 12'h050);
        void'(sb.pop_front());
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 12'h051);
        e = sb.pop_front();
        got = '{prog_ctr, target, r0, r1, r2, accumulator_ctr};
        checks++;
        if (got !== e || got !== '0) begin
            errors++;
            $display("FAIL reset_branch: got %h want %h", got, e);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 40) == 0), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0),
                  8'($urandom), 12'($urandom));
            e = sb.pop_front();
            got = '{prog_ctr, target, r0, r1, r2, accumulator_ctr};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b %0d: got %h want %h", i, got, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1; branch_flag = 1'b0; put_en = 1'b0; op_en = 1'b0;
        value = '0; control_ctr = '0;
        test_reset;
        test_seq_fetch;
        test_wrap;
        test_puts;
        test_op;
        test_branch;
        test_reset_branch;
        test_back_to_back;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
